stat_scheduler: RTL
===================

// Module: stat_scheduler
// PURPOSE
//  Timebase and update scheduler for the pet's three need counters (energy, hunger, entertainment).
//  Owns the stat registers:
//   - generates the 1 ms tick;
//   - runs one decay/recovery period timer per stat;
//   - arbitrates simultaneous decay, recovery, feed and test-preset writes.
//  Sits beside the pet state FSM: consumes its 4-bit state code and feeds the stats back to it.
// PARAMETERS
//  CLK_DIV    50000  clk cycles per ms tick (>=2)
//  ENER_MS    40000  ms ticks per energy event (>=1)
//  FEED_MS    10000  ms ticks per hunger decay event (>=1)
//  ENTERT_MS  20000  ms ticks per entertainment event (>=1)
//  STAT_MAX   5      saturation ceiling of every stat (<=7)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active-high
//  state          in   4  FSM state code: 0 IDLE, 1 NEUTRAL, 2 TIRED, 3 SLEEP, 4 HUNGRY, 5 SAD, 6 PLAYING, 7 BORED, 8 DEATH, 9 TEST
//  feed_btn       in   1  feed button level (already debounced)
//  preset_load    in   1  one-cycle strobe: load test preset
//  preset_sel     in   4  preset index for preset_load
//  tick_ms        out  1  one-cycle pulse per ms
//  energy         out  3  energy stat
//  hunger         out  3  hunger stat
//  entertainment  out  3  entertainment stat
//  any_zero       out  1  high while any stat == 0 (combinational from stat regs)
// BEHAVIOUR
//  Reset
//   - Sampled on posedge clk only.
//   - Stats <= STAT_MAX; prescaler, period counters and feed edge register <= 0; tick_ms <= 0.
//  Prescaler
//   - Counts 0..CLK_DIV-1, wraps.
//   - tick_ms is registered high for exactly the cycle after the count reaches CLK_DIV-1: first pulse on clock CLK_DIV after reset.
//  Period timers
//   - Three independent counters, advance only on tick_ms.
//   - Each fires an event (one cycle, internal) when it reaches its PERIOD-1, and wraps to 0 on the same tick.
//   - Stats update one clk after the event.
//  Energy event
//   - state==SLEEP: +1, saturate at STAT_MAX.
//   - Else: -1, saturate at 0.
//  Hunger
//   - Event: -1, saturate at 0.
//   - Rising edge of feed_btn: +1, saturate at STAT_MAX.
//   - Edge and event in the same cycle: net 0, hunger unchanged.
//  Entertainment event
//   - state==PLAYING: +1, saturate at STAT_MAX.
//   - Else: -1, saturate at 0.
//  DEATH (8)
//   - All stat updates suppressed, including feed.
//   - Timers keep running.
//  TEST (9)
//   - Timers and stats frozen; only preset_load acts.
//  preset_load (highest priority, any state)
//   - Writes {energy,hunger,entertainment} next cycle per preset_sel:
//     1:5,5,5  2:4,4,4  3:2,5,5  4:2,5,5  5:5,2,5  6:2,2,5  7:5,5,2  8:5,5,2  9:0,0,0.
//   - Clears all three period counters; the prescaler is not cleared.
//   - preset_sel 0 or 10-15: strobe ignored entirely.
//  Invalid state codes (10-15) are treated as NEUTRAL (decay only).
//  Arithmetic: 3-bit stats, never wrap; period counters sized $clog2(PERIOD+1).
// CONFIGURATION
//  STAT_SCHED_FAST_EN
//   - Defined: prescaler removed; tick_ms is constant 1, so timers advance every clk (simulation/demo speed).
//   - Undefined: normal CLK_DIV prescaler as above.
//   - All other behaviour is identical.
// TESTING  (bench params: CLK_DIV=4 ENER_MS=3 FEED_MS=2 ENTERT_MS=5)
//  1. rst 1 cycle -> stats 5,5,5, tick_ms 0; tick_ms pulses on clocks 4, 8, 12 ... exactly one cycle wide.
//  2. state=1 from reset -> hunger 4 after 2nd tick, energy 4 after 3rd, entertainment 4 after 5th; hunger 0 after 10th and stays 0; any_zero=1.
//  3. preset 4 then state=3 -> energy 2->3->4->5 on every 3rd tick, then holds 5; hunger keeps decaying.
//  4. feed_btn rising in the event cycle of hunger=3 -> stays 3; feed_btn held high 20 cycles at hunger 4 -> 5 once; at 5 -> stays 5.
//  5. preset_load sel=6 -> 2,2,5 next cycle and period counters 0; sel=0 or 12 -> no change.
//  6. state=8 with stats 3,3,3 over 20 ticks plus feed -> unchanged; rst mid-period -> 5,5,5 and counters 0 next cycle.

Source files
------------

// File: rtl/stat_scheduler.sv
// ---------------------------------------------------------------------------
// stat_scheduler
//
// Timebase and update scheduler for the pet's three need counters (energy,
// hunger, entertainment). Owns the stat registers, generates the 1 ms tick,
// runs one decay/recovery period timer per stat, and arbitrates simultaneous
// timer events, feed presses and test-preset writes.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   state[3:0]     in   pet FSM state code (8 DEATH, 9 TEST, 3 SLEEP, 6 PLAYING)
//   feed_btn       in   debounced feed button level
//   preset_load    in   one-cycle strobe: load test preset selected by preset_sel
//   preset_sel[3:0]in   preset index (1..9 valid, others ignored)
//   tick_ms        out  one-cycle pulse per ms tick
//   energy[2:0]    out  energy stat
//   hunger[2:0]    out  hunger stat
//   entertainment[2:0] out entertainment stat
//   any_zero       out  high while any stat is zero (combinational)
//
// Configuration macro
//   STAT_SCHED_FAST_EN  when defined, the prescaler is removed and tick_ms is
//                       tied high so the period timers advance every clock.
// ---------------------------------------------------------------------------
module stat_scheduler #(
  parameter int CLK_DIV   = 50000,
  parameter int ENER_MS   = 40000,
  parameter int FEED_MS   = 10000,
  parameter int ENTERT_MS = 20000,
  parameter int STAT_MAX  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       feed_btn,
  input  logic       preset_load,
  input  logic [3:0] preset_sel,
  output logic       tick_ms,
  output logic [2:0] energy,
  output logic [2:0] hunger,
  output logic [2:0] entertainment,
  output logic       any_zero
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_NEUTRAL = 4'd1,
    ST_TIRED   = 4'd2,
    ST_SLEEP   = 4'd3,
    ST_HUNGRY  = 4'd4,
    ST_SAD     = 4'd5,
    ST_PLAYING = 4'd6,
    ST_BORED   = 4'd7,
    ST_DEATH   = 4'd8,
    ST_TEST    = 4'd9
  } state_e;

  localparam logic [2:0] SMAX = 3'(STAT_MAX);

  localparam int EW = $clog2(ENER_MS + 1);
  localparam int HW = $clog2(FEED_MS + 1);
  localparam int NW = $clog2(ENTERT_MS + 1);
  localparam logic [EW-1:0] E_LAST = EW'(ENER_MS - 1);
  localparam logic [HW-1:0] H_LAST = HW'(FEED_MS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(ENTERT_MS - 1);

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= SMAX) ? SMAX : v + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // ---------------------------------------------------------------- tick --
`ifdef STAT_SCHED_FAST_EN
  assign tick_ms = 1'b1;
`else
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_cnt;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of the others; = here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      tick_ms <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick_ms <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick_ms <= 1'b0;
    end
  end
`endif

  // -------------------------------------------------------- preset decode --
  logic       preset_ok;
  logic       preset_hit;
  logic [2:0] p_e, p_h, p_n;

  // NOTE: every output of this block gets a default before the case, so
  // unlisted preset_sel values cannot infer latches.
  always_comb begin
    preset_ok       = 1'b1;
    {p_e, p_h, p_n} = {3'd0, 3'd0, 3'd0};
    case (preset_sel)
      4'd1:    {p_e, p_h, p_n} = {3'd5, 3'd5, 3'd5};
      4'd2:    {p_e, p_h, p_n} = {3'd4, 3'd4, 3'd4};
      4'd3:    {p_e, p_h, p_n} = {3'd2, 3'd5, 3'd5};
      4'd4:    {p_e, p_h, p_n} = {3'd2, 3'd5, 3'd5};
      4'd5:    {p_e, p_h, p_n} = {3'd5, 3'd2, 3'd5};
      4'd6:    {p_e, p_h, p_n} = {3'd2, 3'd2, 3'd5};
      4'd7:    {p_e, p_h, p_n} = {3'd5, 3'd5, 3'd2};
      4'd8:    {p_e, p_h, p_n} = {3'd5, 3'd5, 3'd2};
      4'd9:    {p_e, p_h, p_n} = {3'd0, 3'd0, 3'd0};
      default: preset_ok = 1'b0;
    endcase
  end

  assign preset_hit = preset_load && preset_ok;

  // -------------------------------------------------------- period timers --
  logic [EW-1:0] e_cnt;
  logic [HW-1:0] h_cnt;
  logic [NW-1:0] n_cnt;

  // TEST freezes the timers; DEATH lets them run but blocks stat writes.
  logic timer_run, upd_en;
  assign timer_run = (state != ST_TEST);
  assign upd_en    = (state != ST_TEST) && (state != ST_DEATH);

  // Events are one-cycle strobes during the tick cycle in which the counter
  // sits at PERIOD-1; the counter wraps on that same tick.
  logic ev_e, ev_h, ev_n;
  assign ev_e = timer_run && tick_ms && (e_cnt == E_LAST);
  assign ev_h = timer_run && tick_ms && (h_cnt == H_LAST);
  assign ev_n = timer_run && tick_ms && (n_cnt == N_LAST);

  always_ff @(posedge clk) begin
    if (rst || preset_hit) begin
      e_cnt <= '0;
      h_cnt <= '0;
      n_cnt <= '0;
    end else if (timer_run && tick_ms) begin
      e_cnt <= ev_e ? '0 : e_cnt + 1'b1;
      h_cnt <= ev_h ? '0 : h_cnt + 1'b1;
      n_cnt <= ev_n ? '0 : n_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- stats --
  logic feed_q;
  logic feed_rise;
  assign feed_rise = feed_btn && !feed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      feed_q        <= 1'b0;
      energy        <= SMAX;
      hunger        <= SMAX;
      entertainment <= SMAX;
    end else begin
      feed_q <= feed_btn;
      if (preset_hit) begin
        energy        <= p_e;
        hunger        <= p_h;
        entertainment <= p_n;
      end else if (upd_en) begin
        if (ev_e)
          energy <= (state == ST_SLEEP) ? sat_inc(energy) : sat_dec(energy);
        // A feed press coinciding with a decay event cancels out.
        if (ev_h && !feed_rise)
          hunger <= sat_dec(hunger);
        else if (feed_rise && !ev_h)
          hunger <= sat_inc(hunger);
        if (ev_n)
          entertainment <= (state == ST_PLAYING) ? sat_inc(entertainment)
                                                 : sat_dec(entertainment);
      end
    end
  end

  assign any_zero = (energy == 3'd0) || (hunger == 3'd0) || (entertainment == 3'd0);

endmodule
